// File: rtl/scs8hd_o31a_dfilt.sv
// scs8hd_o31a_dfilt
// Registered, deglitched consumer of the o31a term X_raw = (A1|A2|A3)&B1.
// The raw term is synchronised into the CLK domain. A level change reaches X
// only after it has disagreed with X for FILT_LEN consecutive enabled cycles.
// Each filtered edge is reported as a one-cycle XRISE/XFALL pulse and through
// a sticky EVT/OVF event that ACK clears.
module scs8hd_o31a_dfilt #(
    parameter int SYNC_STAGES = 2,  // synchroniser depth, 2..4
    parameter int FILT_CNT_W  = 4,  // stability counter width
    parameter int FILT_LEN    = 5   // 1..2^FILT_CNT_W-1, 1 = no filtering
) (
`ifdef SC_USE_PG_PIN
    input  logic vpwr,
    input  logic vgnd,
    input  logic vpb,
    input  logic vnb,
`endif
    input  logic CLK,
    input  logic RESETB,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic B1,
    input  logic EN,
    input  logic ACK,
    output logic X,
    output logic XRISE,
    output logic XFALL,
    output logic EVT,
    output logic EVT_DIR,
    output logic OVF
);

`ifndef SC_USE_PG_PIN
    supply1 vpwr;
    supply1 vpb;
    supply0 vgnd;
    supply0 vnb;
`endif

    // Power/bias pins carry no logic function; they are only tied off here.
    logic w_unused_pg;
    assign w_unused_pg = vpwr & vpb & ~vgnd & ~vnb;

    // Last count value before the filtered output is allowed to move.
    localparam logic [FILT_CNT_W-1:0] LP_CNT_LAST = FILT_CNT_W'(FILT_LEN - 1);
    localparam logic [FILT_CNT_W-1:0] LP_CNT_ZERO = {FILT_CNT_W{1'b0}};
    localparam logic [FILT_CNT_W-1:0] LP_CNT_ONE  = FILT_CNT_W'(1);

    // Event state encoding: bit 0 is EVT and bit 1 is OVF, so both outputs
    // come straight from the state flops with no decode after them.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PEND = 2'b01,
        ST_LOST = 2'b11
    } evt_state_t;

    logic                   w_x_raw;
    logic                   w_s;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [FILT_CNT_W-1:0]  r_cnt;
    logic [FILT_CNT_W-1:0]  w_cnt_nxt;
    logic                   r_x;
    logic                   w_x_nxt;
    logic                   w_edge;
    logic                   r_xrise;
    logic                   r_xfall;
    logic                   r_evt_dir;
    logic                   w_evt_dir_nxt;
    evt_state_t             r_state;
    evt_state_t             w_state_nxt;

    // The o31a function itself; purely combinational and possibly glitchy.
    assign w_x_raw = (A1 | A2 | A3) & B1;

    // Synchronised view of the raw term.
    assign w_s = r_sync[SYNC_STAGES-1];

    // Synchroniser chain; runs every cycle independent of EN.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            r_sync <= {SYNC_STAGES{1'b0}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_x_raw};
        end
    end

    // Stability filter: count consecutive disagreements, move X on the last one.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_x_nxt   = r_x;
        w_edge    = 1'b0;
        if (!EN) begin
            w_cnt_nxt = LP_CNT_ZERO;
        end else if (w_s == r_x) begin
            w_cnt_nxt = LP_CNT_ZERO;
        end else if (r_cnt >= LP_CNT_LAST) begin
            // >= rather than == so an upset counter can never run past the end.
            w_x_nxt   = w_s;
            w_cnt_nxt = LP_CNT_ZERO;
            w_edge    = 1'b1;
        end else begin
            w_cnt_nxt = r_cnt + LP_CNT_ONE;
        end
    end

    // Filter state plus the edge pulses, which line up with the X change.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            r_cnt   <= LP_CNT_ZERO;
            r_x     <= 1'b0;
            r_xrise <= 1'b0;
            r_xfall <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_x     <= w_x_nxt;
            r_xrise <= w_edge & w_x_nxt;
            r_xfall <= w_edge & ~w_x_nxt;
        end
    end

    // Event FSM next state: a new edge always wins over a simultaneous ACK.
    always_comb begin
        w_state_nxt   = r_state;
        w_evt_dir_nxt = r_evt_dir;
        case (r_state)
            ST_IDLE: begin
                if (w_edge) begin
                    w_state_nxt = ST_PEND;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PEND, ST_LOST: begin
                if (w_edge && ACK) begin
                    w_state_nxt = ST_PEND;
                end else if (w_edge) begin
                    w_state_nxt = ST_LOST;
                end else if (ACK) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                // Unreachable encoding: recover to IDLE, but keep a fresh edge.
                if (w_edge) begin
                    w_state_nxt = ST_PEND;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
        if (w_edge) begin
            w_evt_dir_nxt = w_x_nxt;
        end else begin
            w_evt_dir_nxt = r_evt_dir;
        end
    end

    // Event FSM state and direction registers.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            r_state   <= ST_IDLE;
            r_evt_dir <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_evt_dir <= w_evt_dir_nxt;
        end
    end

    assign X       = r_x;
    assign XRISE   = r_xrise;
    assign XFALL   = r_xfall;
    assign EVT     = r_state[0];
    assign OVF     = r_state[1];
    assign EVT_DIR = r_evt_dir;

endmodule

// File: tb/tb_scs8hd_o31a_dfilt.sv
// Directed bench for scs8hd_o31a_dfilt with default parameters.
// Expected output words {X,XRISE,XFALL,EVT,EVT_DIR,OVF} are queued against an
// absolute clock-edge number when stimulus is driven and compared when that
// edge has been sampled.
module tb_scs8hd_o31a_dfilt;

    logic CLK = 1'b0;
    logic RESETB;
    logic A1, A2, A3, B1, EN, ACK;
    logic X, XRISE, XFALL, EVT, EVT_DIR, OVF;

    typedef struct {
        int          cyc;
        string       tag;
        logic [5:0]  v;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   ncyc   = 0;

    scs8hd_o31a_dfilt #(
        .SYNC_STAGES(2),
        .FILT_CNT_W (4),
        .FILT_LEN   (5)
    ) dut (
        .CLK    (CLK),
        .RESETB (RESETB),
        .A1     (A1),
        .A2     (A2),
        .A3     (A3),
        .B1     (B1),
        .EN     (EN),
        .ACK    (ACK),
        .X      (X),
        .XRISE  (XRISE),
        .XFALL  (XFALL),
        .EVT    (EVT),
        .EVT_DIR(EVT_DIR),
        .OVF    (OVF)
    );

    always #5 CLK = ~CLK;

    function automatic logic [5:0] obs();
        return {X, XRISE, XFALL, EVT, EVT_DIR, OVF};
    endfunction

    task automatic chk(input string tag, input logic [5:0] o, input logic [5:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b (X,XRISE,XFALL,EVT,EVT_DIR,OVF)", tag, o, e);
        end
    endtask

    task automatic expect_at(input int dly, input string tag, input logic [5:0] v);
        q.push_back('{cyc: ncyc + dly, tag: tag, v: v});
    endtask

    task automatic tick();
        @(posedge CLK);
        ncyc++;
        #1;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == ncyc) begin
                chk(q[i].tag, obs(), q[i].v);
                q.delete(i);
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        RESETB = 1'b0;
        A1 = 1'b0; A2 = 1'b0; A3 = 1'b0; B1 = 1'b0;
        EN = 1'b0; ACK = 1'b0;

        // Reset state held across clock edges.
        expect_at(1, "rst_hold1", 6'b000000);
        expect_at(2, "rst_hold2", 6'b000000);
        run(3);
        RESETB = 1'b1;

        // First rise: X_raw high before edge 0, X moves on edge 6.
        A1 = 1'b1; B1 = 1'b1; EN = 1'b1;
        for (int k = 1; k <= 6; k++) expect_at(k, "rise_wait", 6'b000000);
        expect_at(7, "rise_edge6", 6'b110110);
        expect_at(8, "rise_edge7", 6'b100110);
        run(8);

        // ACK from PEND clears EVT, EVT_DIR held.
        ACK = 1'b1;
        expect_at(1, "ack_pend", 6'b100010);
        run(1);
        ACK = 1'b0;

        // Four-cycle low glitch on B1 never reaches X.
        B1 = 1'b0;
        for (int k = 1; k <= 8; k++) expect_at(k, "glitch4", 6'b100010);
        run(4);
        B1 = 1'b1;
        run(4);

        // Five-cycle low pulse: fall on edge 6, then the restored high rises
        // again while EVT is still pending, which overflows.
        B1 = 1'b0;
        for (int k = 1; k <= 6; k++) expect_at(k, "pulse5_wait", 6'b100010);
        expect_at(7, "pulse5_fall", 6'b001100);
        for (int k = 8; k <= 11; k++) expect_at(k, "fall_pend", 6'b000100);
        expect_at(12, "ovf_rise", 6'b110111);
        expect_at(13, "ovf_hold", 6'b100111);
        run(5);
        B1 = 1'b1;
        run(8);

        // ACK from LOST clears both EVT and OVF.
        ACK = 1'b1;
        expect_at(1, "ack_lost", 6'b100010);
        run(1);
        ACK = 1'b0;

        // Fall, then a rise whose edge coincides with ACK: new event wins.
        B1 = 1'b0;
        for (int k = 1; k <= 6; k++) expect_at(k, "pre_fall", 6'b100010);
        expect_at(7, "fall2", 6'b001100);
        for (int k = 8; k <= 13; k++) expect_at(k, "fall2_pend", 6'b000100);
        expect_at(14, "ack_edge", 6'b110110);
        expect_at(15, "ack_edge_hold", 6'b100110);
        run(7);
        B1 = 1'b1;
        run(6);
        ACK = 1'b1;
        run(1);
        ACK = 1'b0;
        run(1);

        // Bring X back to 0 with EVT cleared before the enable test.
        ACK = 1'b1;
        expect_at(1, "ack_pre_en", 6'b100010);
        run(1);
        ACK = 1'b0;
        B1 = 1'b0;
        expect_at(7, "fall3", 6'b001100);
        expect_at(8, "fall3_hold", 6'b000100);
        run(8);
        ACK = 1'b1;
        expect_at(1, "ack_fall3", 6'b000000);
        run(1);
        ACK = 1'b0;

        // EN=0 freezes X and the counter while X_raw sits high.
        EN = 1'b0;
        B1 = 1'b1;
        for (int k = 1; k <= 20; k++) expect_at(k, "en0_frozen", 6'b000000);
        run(20);
        chk("en0_cnt", {2'b00, dut.r_cnt}, 6'd0);
        EN = 1'b1;
        for (int k = 1; k <= 4; k++) expect_at(k, "en1_wait", 6'b000000);
        expect_at(5, "en1_rise", 6'b110110);
        expect_at(6, "en1_hold", 6'b100110);
        run(6);

        // Asynchronous reset mid-count with EVT pending.
        B1 = 1'b0;
        for (int k = 1; k <= 5; k++) expect_at(k, "midcount", 6'b100110);
        run(5);
        chk("cnt_mid", {2'b00, dut.r_cnt}, 6'd3);
        #2;
        RESETB = 1'b0;
        #1;
        chk("rst_async", obs(), 6'b000000);
        chk("rst_cnt", {2'b00, dut.r_cnt}, 6'd0);
        B1 = 1'b1;
        expect_at(1, "rst_low1", 6'b000000);
        expect_at(2, "rst_low2", 6'b000000);
        run(2);
        RESETB = 1'b1;

        // After release a high X_raw is a fresh rising edge.
        for (int k = 1; k <= 6; k++) expect_at(k, "post_rst_wait", 6'b000000);
        expect_at(7, "post_rst_rise", 6'b110110);
        expect_at(8, "post_rst_hold", 6'b100110);
        run(8);

        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL queue_drain observed=%0d expected=0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
